dm_core: RTL and testbench
==========================

DM_CORE -- requirements
Module: dm_core

Interface
REQ-001 The parameter DM_WORDS SHALL default to 3072 and SHALL set the memory depth in 32-bit words.
REQ-002 The parameter DM_LIMIT SHALL default to 32'h0000_3000 and SHALL be the first byte address outside the memory.
REQ-003 Port clk SHALL be an input, 1 bit wide, and SHALL be the single clock; all writes occur on its rising edge.
REQ-004 Port reset SHALL be an input, 1 bit wide, asynchronous and active-low (0 = reset asserted).
REQ-005 Port addr SHALL be an input, 32 bits wide, carrying the M-stage byte address (ALU result).
REQ-006 Port wdata SHALL be an input, 32 bits wide, carrying the forwarded store data (rt), right-aligned.
REQ-007 Port writedm_op SHALL be an input, 2 bits wide: 0 = none, 1 = sw, 2 = sh, 3 = sb.
REQ-008 Port readdm_op SHALL be an input, 3 bits wide: 0 = none/lw, 1 = lbu, 2 = lb, 3 = lhu, 4 = lh, 5 = lw; this is the same encoding consumed by the downstream extender.
REQ-009 Port exc_flush SHALL be an input, 1 bit wide; 1 means the M-stage instruction is being killed by an interrupt or exception this cycle.
REQ-010 Port dm_out SHALL be an output, 32 bits wide, carrying the raw aligned word at addr[31:2] and feeding the read-extend stage.
REQ-011 Port byte_en SHALL be an output, 4 bits wide, carrying the effective byte-write strobes for this cycle.
REQ-012 Port exc_ades SHALL be an output, 1 bit wide, flagging a store address error.
REQ-013 Port exc_adel SHALL be an output, 1 bit wide, flagging a load address error.

Function
REQ-014 dm_out SHALL be combinational: mem[addr[13:2]] when addr < DM_LIMIT, else 32'h0.
REQ-015 Raw strobes SHALL be:
- sw: 4'b1111
- sh: 4'b0011 when addr[1] = 0, 4'b1100 when addr[1] = 1
- sb: one-hot 1 << addr[1:0]
- none: 4'b0000
REQ-016 The write lane data SHALL be wdata replicated per op: sw = wdata; sh = {2{wdata[15:0]}}; sb = {4{wdata[7:0]}}.
REQ-017 exc_ades SHALL be 1 when writedm_op != 0 and any of the following holds: addr >= DM_LIMIT; sw with addr[1:0] != 0; sh with addr[0] = 1.
REQ-018 exc_adel SHALL be 1 when readdm_op is in {3, 4} and addr[0] = 1, when readdm_op = 5 and addr[1:0] != 0, or when readdm_op != 0 and addr >= DM_LIMIT.
REQ-019 byte_en SHALL equal the raw strobes gated to 4'b0000 whenever exc_ades = 1 or exc_flush = 1.
REQ-020 On each rising clk with reset high, every byte lane i with byte_en[i] = 1 SHALL be written at mem[addr[13:2]]; all other lanes SHALL hold.
REQ-021 Write latency SHALL be one cycle: a load to the same address in the following cycle SHALL see the new data on dm_out.
REQ-022 For a read and write to the same word in the same cycle, dm_out SHALL show the pre-edge (old) data.
REQ-023 Address wrap-around SHALL be impossible: any addr >= DM_LIMIT, including addresses whose addr[13:2] aliases a valid word, SHALL never be written.
REQ-024 If writedm_op != 0 and readdm_op != 0 in the same cycle (illegal decode), the write SHALL take precedence and exc_adel SHALL be forced to 0.

Reset
REQ-025 Asserting reset (0) SHALL asynchronously clear every memory word to 32'h0 without waiting for clk.
REQ-026 A write whose clock edge coincides with reset asserted SHALL be discarded.
REQ-027 During reset, dm_out SHALL read 32'h0, and byte_en SHALL follow REQ-019; only exc_ades and exc_adel remain pure functions of their inputs.
REQ-028 Deassertion of reset SHALL take effect at the next rising clk, and no write SHALL occur on the deassertion edge itself.

Structure
REQ-029 A shared package dm_pkg SHALL hold the writedm_op and readdm_op encodings, DM_WORDS and DM_LIMIT defaults, and the MIPS exception codes ADEL = 4 and ADES = 5; the extender and CP0 import the same package.
REQ-030 A single sub-module dm_be SHALL be purely combinational and SHALL produce the raw strobes, lane data and exc_ades from addr and writedm_op.
REQ-031 The memory array, read mux, gating and exc_adel logic SHALL remain in dm_core.

Verification
REQ-032 sw 0x12345678 at 0x100, then readdm_op = 5 at 0x100 next cycle -> dm_out = 0x12345678, byte_en = 1111 during the store, no exceptions.
REQ-033 sb 0xAB at 0x101 over word 0x00000000, then read 0x100 -> dm_out = 0x0000AB00, byte_en = 0010.
REQ-034 sh at 0x103 -> exc_ades = 1, byte_en = 0000, memory unchanged; lh at 0x101 -> exc_adel = 1.
REQ-035 sw to 0x3000 and 0x7FFC -> exc_ades = 1, no write; a subsequent read of 0x0000 and 0x0FFC shows no aliasing corruption.
REQ-036 sw 0xFFFFFFFF at 0x200 with exc_flush = 1 -> no write, and a read of 0x200 returns the old value.
REQ-037 Fill 0x0–0x10 with data, pulse reset low mid-cycle between edges -> dm_out = 0 immediately, and all reads return 0 after release.

Source files
------------

// File: rtl/dm_pkg.sv
// rtl/dm_pkg.sv - shared data-memory op encodings, size defaults and address-error exception codes
package dm_pkg;

  typedef enum logic [1:0] {
    WOP_NONE = 2'd0,
    WOP_SW   = 2'd1,
    WOP_SH   = 2'd2,
    WOP_SB   = 2'd3
  } wop_e;

  // Same encoding the read extender consumes; 0 doubles as "no load".
  typedef enum logic [2:0] {
    ROP_NONE = 3'd0,
    ROP_LBU  = 3'd1,
    ROP_LB   = 3'd2,
    ROP_LHU  = 3'd3,
    ROP_LH   = 3'd4,
    ROP_LW   = 3'd5
  } rop_e;

  localparam int unsigned DM_WORDS_DEF = 3072;
  localparam logic [31:0] DM_LIMIT_DEF = 32'h0000_3000;

  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;

endpackage

// File: rtl/dm_be.sv
// rtl/dm_be.sv - store decode: raw byte strobes, replicated lane data and store address error
module dm_be
  import dm_pkg::*;
#(
  parameter logic [31:0] DM_LIMIT = DM_LIMIT_DEF
) (
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [1:0]  writedm_op,
  output logic [3:0]  raw_be,
  output logic [31:0] lane_data,
  output logic        exc_ades
);

  logic misaligned;
  logic out_of_range;

  assign out_of_range = (addr >= DM_LIMIT);

  always_comb begin
    raw_be     = 4'b0000;
    lane_data  = wdata;
    misaligned = 1'b0;
    case (writedm_op)
      WOP_SW: begin
        raw_be     = 4'b1111;
        lane_data  = wdata;
        misaligned = (addr[1:0] != 2'b00);
      end
      WOP_SH: begin
        raw_be     = addr[1] ? 4'b1100 : 4'b0011;
        lane_data  = {2{wdata[15:0]}};
        misaligned = addr[0];
      end
      WOP_SB: begin
        raw_be    = 4'b0001 << addr[1:0];
        lane_data = {4{wdata[7:0]}};
      end
      default: ;
    endcase
    exc_ades = (writedm_op != WOP_NONE) && (out_of_range || misaligned);
  end

endmodule

// File: rtl/dm_core.sv
// rtl/dm_core.sv - M-stage data memory: byte-strobed writes, combinational aligned read, address errors
module dm_core
  import dm_pkg::*;
#(
  parameter int unsigned DM_WORDS = DM_WORDS_DEF,
  parameter logic [31:0] DM_LIMIT = DM_LIMIT_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [1:0]  writedm_op,
  input  logic [2:0]  readdm_op,
  input  logic        exc_flush,
  output logic [31:0] dm_out,
  output logic [3:0]  byte_en,
  output logic        exc_ades,
  output logic        exc_adel
);

  logic [31:0] mem [DM_WORDS];
  logic [3:0]  raw_be;
  logic [31:0] lane_data;
  logic [11:0] word_idx;
  logic        in_range;
  logic        wr_live;

  assign word_idx = addr[13:2];
  assign in_range = (addr < DM_LIMIT);

  dm_be #(
    .DM_LIMIT (DM_LIMIT)
  ) u_dm_be (
    .addr       (addr),
    .wdata      (wdata),
    .writedm_op (writedm_op),
    .raw_be     (raw_be),
    .lane_data  (lane_data),
    .exc_ades   (exc_ades)
  );

  // Out-of-range stores already raise exc_ades, so gating on it also blocks aliasing writes.
  assign byte_en = (exc_ades || exc_flush) ? 4'b0000 : raw_be;

  always_comb begin
    exc_adel = 1'b0;
    if (writedm_op == WOP_NONE && readdm_op != ROP_NONE) begin
      if (!in_range)
        exc_adel = 1'b1;
      else if ((readdm_op == ROP_LHU || readdm_op == ROP_LH) && addr[0])
        exc_adel = 1'b1;
      else if (readdm_op == ROP_LW && addr[1:0] != 2'b00)
        exc_adel = 1'b1;
    end
  end

  assign dm_out = (reset && in_range) ? mem[word_idx] : 32'h0;

  // Writes are held off until the first edge after reset release has been seen.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      wr_live <= 1'b0;
    else
      wr_live <= 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DM_WORDS; i++)
        mem[i] <= 32'h0;
    end else if (wr_live) begin
      for (int b = 0; b < 4; b++)
        if (byte_en[b])
          mem[word_idx][8*b +: 8] <= lane_data[8*b +: 8];
    end
  end

endmodule

// File: tb/tb_dm_core.sv
// tb/tb_dm_core.sv - vector table, directed corner sequences and randomized byte-memory model for dm_core
module tb_dm_core;

  localparam logic [31:0] LIM = 32'h0000_3000;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [1:0]  writedm_op;
  logic [2:0]  readdm_op;
  logic        exc_flush;
  logic [31:0] dm_out;
  logic [3:0]  byte_en;
  logic        exc_ades;
  logic        exc_adel;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] mb [12288];

  typedef struct {
    logic [1:0]  wop;
    logic [2:0]  rop;
    logic [31:0] a;
    logic        fl;
    logic [3:0]  be;
    logic        ades;
    logic        adel;
  } vec_t;

  vec_t tbl [20];

  always #5 clk = ~clk;

  dm_core dut (
    .clk        (clk),
    .reset      (reset),
    .addr       (addr),
    .wdata      (wdata),
    .writedm_op (writedm_op),
    .readdm_op  (readdm_op),
    .exc_flush  (exc_flush),
    .dm_out     (dm_out),
    .byte_en    (byte_en),
    .exc_ades   (exc_ades),
    .exc_adel   (exc_adel)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [1:0] w, input logic [2:0] r, input logic [31:0] a,
                       input logic [31:0] d, input logic f);
    @(negedge clk);
    writedm_op = w;
    readdm_op  = r;
    addr       = a;
    wdata      = d;
    exc_flush  = f;
    #1;
  endtask

  function automatic logic m_ades(input logic [1:0] w, input logic [31:0] a);
    return (w != 2'd0) && (a >= LIM || (w == 2'd1 && a[1:0] != 2'b00) || (w == 2'd2 && a[0]));
  endfunction

  function automatic logic m_adel(input logic [1:0] w, input logic [2:0] r, input logic [31:0] a);
    if (w != 2'd0 || r == 3'd0) return 1'b0;
    return (a >= LIM) || ((r == 3'd3 || r == 3'd4) && a[0]) || (r == 3'd5 && a[1:0] != 2'b00);
  endfunction

  // Store covers the bytes from addr upward: 4 for sw, 2 for sh, 1 for sb.
  function automatic logic [3:0] m_be(input logic [1:0] w, input logic [31:0] a, input logic f);
    int n;
    logic [3:0] m;
    if (w == 2'd0 || f || m_ades(w, a)) return 4'b0000;
    n = (w == 2'd1) ? 4 : (w == 2'd2) ? 2 : 1;
    m = 4'b0000;
    for (int k = 0; k < n; k++) m[(a % 4) + k] = 1'b1;
    return m;
  endfunction

  function automatic logic [31:0] m_rd(input logic [31:0] a);
    int base;
    if (a >= LIM) return 32'h0;
    base = int'(a) & ~3;
    return {mb[base+3], mb[base+2], mb[base+1], mb[base]};
  endfunction

  task automatic m_store(input logic [1:0] w, input logic [31:0] a, input logic [31:0] d,
                         input logic f);
    logic [3:0] m;
    int base;
    int k;
    m = m_be(w, a, f);
    base = int'(a) & ~3;
    for (int i = 0; i < 4; i++) begin
      if (m[i]) begin
        k = i - int'(a % 4);
        mb[base + i] = 8'(d >> (8 * k));
      end
    end
  endtask

  function automatic logic [31:0] rand_addr();
    int r;
    r = $urandom_range(0, 9);
    if (r < 6)  return 32'($urandom_range(0, 63));
    if (r < 8)  return 32'h2FF0 + 32'($urandom_range(0, 31));
    if (r == 8) return 32'h4000 + 32'($urandom_range(0, 63));
    return $urandom;
  endfunction

  initial begin
    tbl[0]  = '{2'd1, 3'd0, 32'h0000_0100, 1'b0, 4'b1111, 1'b0, 1'b0};
    tbl[1]  = '{2'd1, 3'd0, 32'h0000_0102, 1'b0, 4'b0000, 1'b1, 1'b0};
    tbl[2]  = '{2'd2, 3'd0, 32'h0000_0100, 1'b0, 4'b0011, 1'b0, 1'b0};
    tbl[3]  = '{2'd2, 3'd0, 32'h0000_0102, 1'b0, 4'b1100, 1'b0, 1'b0};
    tbl[4]  = '{2'd2, 3'd0, 32'h0000_0103, 1'b0, 4'b0000, 1'b1, 1'b0};
    tbl[5]  = '{2'd3, 3'd0, 32'h0000_0101, 1'b0, 4'b0010, 1'b0, 1'b0};
    tbl[6]  = '{2'd3, 3'd0, 32'h0000_0103, 1'b0, 4'b1000, 1'b0, 1'b0};
    tbl[7]  = '{2'd1, 3'd0, 32'h0000_3000, 1'b0, 4'b0000, 1'b1, 1'b0};
    tbl[8]  = '{2'd1, 3'd0, 32'h0000_2FFC, 1'b0, 4'b1111, 1'b0, 1'b0};
    tbl[9]  = '{2'd1, 3'd0, 32'h0000_0100, 1'b1, 4'b0000, 1'b0, 1'b0};
    tbl[10] = '{2'd0, 3'd4, 32'h0000_0101, 1'b0, 4'b0000, 1'b0, 1'b1};
    tbl[11] = '{2'd0, 3'd3, 32'h0000_0102, 1'b0, 4'b0000, 1'b0, 1'b0};
    tbl[12] = '{2'd0, 3'd5, 32'h0000_0102, 1'b0, 4'b0000, 1'b0, 1'b1};
    tbl[13] = '{2'd0, 3'd1, 32'h0000_3000, 1'b0, 4'b0000, 1'b0, 1'b1};
    tbl[14] = '{2'd0, 3'd2, 32'h0000_2FFF, 1'b0, 4'b0000, 1'b0, 1'b0};
    tbl[15] = '{2'd0, 3'd0, 32'h0000_3000, 1'b0, 4'b0000, 1'b0, 1'b0};
    tbl[16] = '{2'd1, 3'd5, 32'h0000_0102, 1'b0, 4'b0000, 1'b1, 1'b0};
    tbl[17] = '{2'd3, 3'd4, 32'h0000_0101, 1'b0, 4'b0010, 1'b0, 1'b0};
    tbl[18] = '{2'd3, 3'd0, 32'h0000_7FFC, 1'b0, 4'b0000, 1'b1, 1'b0};
    tbl[19] = '{2'd2, 3'd0, 32'h0000_2FFE, 1'b1, 4'b0000, 1'b0, 1'b0};

    reset = 1'b0; addr = '0; wdata = '0; writedm_op = '0; readdm_op = '0; exc_flush = 1'b0;
    foreach (mb[i]) mb[i] = 8'h00;

    // Decode table applied while reset is held: strobes still follow gating, stores must not land.
    for (int i = 0; i < 20; i++) begin
      drive(tbl[i].wop, tbl[i].rop, tbl[i].a, $urandom, tbl[i].fl);
      chk($sformatf("tbl%0d byte_en", i), 32'(byte_en), 32'(tbl[i].be));
      chk($sformatf("tbl%0d exc_ades", i), 32'(exc_ades), 32'(tbl[i].ades));
      chk($sformatf("tbl%0d exc_adel", i), 32'(exc_adel), 32'(tbl[i].adel));
      chk($sformatf("tbl%0d dm_out_in_reset", i), dm_out, 32'h0);
    end

    drive(2'd0, 3'd0, 32'h0, 32'h0, 1'b0);
    reset = 1'b1;
    drive(2'd0, 3'd0, 32'h0, 32'h0, 1'b0);

    drive(2'd3, 3'd0, 32'h101, 32'h0000_00AB, 1'b0);
    chk("sb byte_en", 32'(byte_en), 32'h2);
    drive(2'd0, 3'd5, 32'h100, 32'h0, 1'b0);
    chk("sb readback", dm_out, 32'h0000_AB00);

    drive(2'd1, 3'd0, 32'h100, 32'h1234_5678, 1'b0);
    chk("sw byte_en", 32'(byte_en), 32'hF);
    chk("sw no exc", 32'({exc_ades, exc_adel}), 32'h0);
    chk("sw same-cycle old data", dm_out, 32'h0000_AB00);
    drive(2'd0, 3'd5, 32'h100, 32'h0, 1'b0);
    chk("lw after sw", dm_out, 32'h1234_5678);
    chk("lw no adel", 32'(exc_adel), 32'h0);

    drive(2'd2, 3'd0, 32'h103, 32'hFFFF_FFFF, 1'b0);
    chk("sh misaligned ades", 32'(exc_ades), 32'h1);
    chk("sh misaligned byte_en", 32'(byte_en), 32'h0);
    drive(2'd0, 3'd4, 32'h101, 32'h0, 1'b0);
    chk("lh misaligned adel", 32'(exc_adel), 32'h1);
    chk("mem unchanged after bad sh", dm_out, 32'h1234_5678);

    drive(2'd1, 3'd0, 32'h3000, 32'hDEAD_BEEF, 1'b0);
    chk("sw 0x3000 ades", 32'(exc_ades), 32'h1);
    drive(2'd1, 3'd0, 32'h7FFC, 32'hDEAD_BEEF, 1'b0);
    chk("sw 0x7FFC ades", 32'(exc_ades), 32'h1);
    drive(2'd1, 3'd0, 32'h4000, 32'hDEAD_BEEF, 1'b0);
    drive(2'd1, 3'd0, 32'h4FFC, 32'hDEAD_BEEF, 1'b0);
    drive(2'd0, 3'd5, 32'h0, 32'h0, 1'b0);
    chk("no alias at 0x0000", dm_out, 32'h0);
    drive(2'd0, 3'd5, 32'hFFC, 32'h0, 1'b0);
    chk("no alias at 0x0FFC", dm_out, 32'h0);
    drive(2'd0, 3'd5, 32'h3000, 32'h0, 1'b0);
    chk("read beyond limit", dm_out, 32'h0);

    drive(2'd1, 3'd0, 32'h200, 32'h1111_2222, 1'b0);
    drive(2'd1, 3'd0, 32'h200, 32'hFFFF_FFFF, 1'b1);
    chk("flush byte_en", 32'(byte_en), 32'h0);
    drive(2'd0, 3'd5, 32'h200, 32'h0, 1'b0);
    chk("flushed store dropped", dm_out, 32'h1111_2222);

    for (int i = 0; i < 5; i++)
      drive(2'd1, 3'd0, 32'(4 * i), 32'hA5A5_0000 + 32'(i + 1), 1'b0);
    drive(2'd0, 3'd5, 32'h8, 32'h0, 1'b0);
    chk("fill readback", dm_out, 32'hA5A5_0003);
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk("async clear immediate", dm_out, 32'h0);
    drive(2'd1, 3'd0, 32'h8, 32'hFFFF_FFFF, 1'b0);
    drive(2'd0, 3'd0, 32'h0, 32'h0, 1'b0);
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive(2'd0, 3'd5, 32'(4 * i), 32'h0, 1'b0);
      chk($sformatf("post-reset word %0d", i), dm_out, 32'h0);
    end
    drive(2'd0, 3'd5, 32'h200, 32'h0, 1'b0);
    chk("post-reset 0x200", dm_out, 32'h0);

    // Memory is all-zero now, matching the cleared byte model.
    for (int i = 0; i < 600; i++) begin
      logic [1:0]  w;
      logic [2:0]  r;
      logic [31:0] a;
      logic [31:0] d;
      logic        f;
      w = 2'($urandom_range(0, 3));
      r = 3'($urandom_range(0, 5));
      a = rand_addr();
      d = $urandom;
      f = ($urandom_range(0, 7) == 0);
      drive(w, r, a, d, f);
      chk($sformatf("rnd%0d byte_en", i), 32'(byte_en), 32'(m_be(w, a, f)));
      chk($sformatf("rnd%0d exc_ades", i), 32'(exc_ades), 32'(m_ades(w, a)));
      chk($sformatf("rnd%0d exc_adel", i), 32'(exc_adel), 32'(m_adel(w, r, a)));
      chk($sformatf("rnd%0d dm_out", i), dm_out, m_rd(a));
      m_store(w, a, d, f);
    end

    for (int i = 0; i < 16; i++) begin
      drive(2'd0, 3'd5, 32'(4 * i), 32'h0, 1'b0);
      chk($sformatf("final word %0d", i), dm_out, m_rd(32'(4 * i)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
